// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/issue/resolve program-counter sequencer
// Optional JR_ALIGN_CHECK_EN: trap misaligned register jumps into a sticky HALT.
module pc_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        decision_valid,
  input  logic [1:0]  jump,
  input  logic [31:0] j_reg,
  input  logic        branch_result,
  input  logic [31:0] branch_destiny,
  output logic [31:0] pc_out,
  output logic [31:0] instr_count,
  output logic        misalign_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ISSUE   = 3'd2,
    RESOLVE = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        err_q, err_d;
  logic [31:0] pc4;
  logic [31:0] next_pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
      count_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // jump=01 splices the raw 26-bit field under pc4's top nibble (no <<2 in this datapath).
  always_comb begin
    pc4 = pc_q + 32'd4;
    case (jump)
      2'b00:   next_pc = pc4;
      2'b01:   next_pc = {pc4[31:28], 2'b00, instr_q[25:0]};
      2'b10:   next_pc = j_reg;
      default: next_pc = branch_result ? branch_destiny : pc4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) state_d = RESOLVE;
      end
      RESOLVE: begin
        if (decision_valid) begin
`ifdef JR_ALIGN_CHECK_EN
          if (jump == 2'b10 && j_reg[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            count_d = count_q + 32'd1;
            state_d = FETCH;
          end
`else
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          state_d = FETCH;
`endif
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req     = (state_q == FETCH);
  assign imem_addr    = pc_q;
  assign instr_out    = instr_q;
  assign instr_valid  = (state_q == ISSUE);
  assign pc_out       = pc_q;
  assign instr_count  = count_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized bench for pc_sequencer against a next-PC reference model
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        decision_valid;
  logic [1:0]  jump;
  logic [31:0] j_reg;
  logic        branch_result;
  logic [31:0] branch_destiny;
  logic [31:0] pc_out;
  logic [31:0] instr_count;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_cnt;
  logic        m_err;
  bit          align_chk;
  bit          halted;
  int          last_wait;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .decision_valid(decision_valid), .jump(jump), .j_reg(j_reg),
    .branch_result(branch_result), .branch_destiny(branch_destiny),
    .pc_out(pc_out), .instr_count(instr_count), .misalign_err(misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic [1:0] j, input logic [31:0] jr,
                                             input logic br, input logic [31:0] bd);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (j == 2'd0) return p4;
    if (j == 2'd1) return (p4 & 32'hF000_0000) | (ins & 32'h03FF_FFFF);
    if (j == 2'd2) return jr;
    return br ? bd : p4;
  endfunction

  task automatic scramble_decision();
    jump           = 2'($urandom_range(0, 3));
    j_reg          = $urandom;
    branch_result  = 1'($urandom_range(0, 1));
    branch_destiny = $urandom;
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    decision_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    chk("rst_req",   imem_req,     0);
    chk("rst_valid", instr_valid,  0);
    chk("rst_pc",    pc_out,       0);
    chk("rst_instr", instr_out,    0);
    chk("rst_cnt",   instr_count,  0);
    chk("rst_err",   misalign_err, 0);
    m_pc = 0;
    m_cnt = 0;
    m_err = 0;
    halted = 0;
    reset_n = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] rdata, input int ack_dly, input int rdy_dly,
                           input int dv_dly, input logic [1:0] jmp, input logic [31:0] jr,
                           input logic br, input logic [31:0] bd);
    int w;
    int reqc;
    w = 0;
    while (!imem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    chk("req_seen", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    reqc = 0;
    for (int i = 0; i < ack_dly; i++) begin
      if (imem_req) reqc++;
      chk("stall_addr", imem_addr, m_pc);
      imem_rdata = $urandom;
      @(negedge clk);
    end
    if (imem_req) reqc++;
    imem_ack = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("req_cycles", reqc, ack_dly + 1);
    chk("req_drop", imem_req, 0);
    chk("issue_valid", instr_valid, 1);
    chk("issue_instr", instr_out, rdata);
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      scramble_decision();
      @(negedge clk);
      chk("hold_instr", instr_out, rdata);
      chk("hold_valid", instr_valid, 1);
      chk("hold_pc", pc_out, m_pc);
    end
    imem_ack = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("resolve_valid", instr_valid, 0);
    for (int i = 0; i < dv_dly; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      scramble_decision();
      @(negedge clk);
      chk("resolve_pc", pc_out, m_pc);
      chk("resolve_cnt", instr_count, m_cnt);
      chk("resolve_instr", instr_out, rdata);
    end
    imem_ack = 1'b0;
    jump = jmp;
    j_reg = jr;
    branch_result = br;
    branch_destiny = bd;
    decision_valid = 1'b1;
    @(negedge clk);
    decision_valid = 1'b0;
    scramble_decision();
    if (align_chk && jmp == 2'd2 && jr[1:0] != 2'd0) begin
      m_err = 1'b1;
      halted = 1'b1;
    end else begin
      m_pc = model_next(m_pc, rdata, jmp, jr, br, bd);
      m_cnt = m_cnt + 1;
    end
    chk("next_pc", pc_out, m_pc);
    chk("count", instr_count, m_cnt);
    chk("misalign", misalign_err, m_err);
    chk("refetch", imem_req, halted ? 0 : 1);
  endtask

  initial begin
    int w;
    logic [31:0] jr;
`ifdef JR_ALIGN_CHECK_EN
    align_chk = 1'b1;
`else
    align_chk = 1'b0;
`endif
    reset_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    instr_ready = 1'b0;
    decision_valid = 1'b0;
    scramble_decision();
    do_reset(2);

    // back-to-back sequential fetches: 0, 4, 8 at three cycles each
    run_instr($urandom, 0, 0, 0, 2'd0, 0, 0, 0);
    chk("idle_len", last_wait, 1);
    run_instr($urandom, 0, 0, 0, 2'd0, 0, 0, 0);
    chk("cpi3_a", last_wait, 0);
    run_instr($urandom, 0, 0, 0, 2'd0, 0, 0, 0);
    chk("cpi3_b", last_wait, 0);
    chk("seq_pc", pc_out, 32'h0000_000C);
    chk("seq_cnt", instr_count, 3);

    run_instr($urandom, 0, 0, 0, 2'd2, 32'h1000_0000, 0, 0);
    run_instr(32'h0800_0040, 0, 0, 0, 2'd1, 0, 0, 0);
    chk("jump01", pc_out, 32'h1000_0040);
    run_instr($urandom, 0, 0, 0, 2'd3, 0, 1'b1, 32'h0000_0200);
    chk("br_taken", pc_out, 32'h0000_0200);
    run_instr($urandom, 0, 0, 0, 2'd3, 0, 1'b0, 32'h0000_0800);
    chk("br_not", pc_out, 32'h0000_0204);
    run_instr($urandom, 0, 0, 0, 2'd2, 32'hFFFF_FFFC, 0, 0);
    run_instr($urandom, 0, 0, 0, 2'd0, 0, 0, 0);
    chk("pc_wrap", pc_out, 32'h0000_0000);
    run_instr($urandom, 5, 3, 2, 2'd0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      if (halted) do_reset(1 + $urandom_range(0, 2));
      jr = $urandom;
      if ($urandom_range(0, 7) != 0) jr[1:0] = 2'b00;
      run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                2'($urandom_range(0, 3)), jr, 1'($urandom_range(0, 1)), $urandom);
    end
    if (halted) do_reset(1);

    // make pc nonzero, then reset in a fetch cycle that also sees imem_ack
    run_instr($urandom, 0, 0, 0, 2'd2, 32'h0000_4440, 0, 0);
    w = 0;
    while (!imem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("abort_req_seen", imem_req, 1);
    reset_n = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("abort_instr", instr_out, 0);
    chk("abort_pc", pc_out, 0);
    chk("abort_cnt", instr_count, 0);
    chk("abort_req", imem_req, 0);
    do_reset(1);

    run_instr($urandom, 0, 0, 0, 2'd2, 32'h0000_0102, 0, 0);
    if (align_chk) begin
      chk("halt_err", misalign_err, 1);
      chk("halt_pc", pc_out, 0);
      for (int i = 0; i < 10; i++) begin
        imem_ack = 1'($urandom_range(0, 1));
        instr_ready = 1'($urandom_range(0, 1));
        decision_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("halt_req", imem_req, 0);
        chk("halt_valid", instr_valid, 0);
        chk("halt_sticky", misalign_err, 1);
      end
      do_reset(1);
    end else begin
      chk("jr_unchecked", pc_out, 32'h0000_0102);
      chk("err_tied", misalign_err, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-low.
REQ-002 Ports, in order (name direction width meaning):
  clk  in  1  rising-edge clock
  reset_n  in  1  synchronous active-low reset
  imem_req  out  1  instruction fetch request
  imem_addr  out  32  fetch address, equal to pc_out
  imem_ack  in  1  fetch complete; imem_rdata valid this cycle
  imem_rdata  in  32  fetched instruction
  instr_out  out  32  latched current instruction
  instr_valid  out  1  instr_out offered to decoder
  instr_ready  in  1  decoder accepts instr_out
  decision_valid  in  1  jump, j_reg, branch inputs valid
  jump  in  2  next-PC source select
  j_reg  in  32  register jump target
  branch_result  in  1  branch taken
  branch_destiny  in  32  branch target
  pc_out  out  32  current PC
  instr_count  out  32  instructions retired
  misalign_err  out  1  sticky misaligned register-jump flag

Function
REQ-003 FSM states SHALL be IDLE, FETCH, ISSUE, RESOLVE, HALT.
REQ-004 IDLE SHALL last exactly one cycle, then go to FETCH.
REQ-005 FETCH: imem_req=1, imem_addr=pc_out; on imem_ack, latch imem_rdata into instr_out and go to ISSUE the next cycle; the FSM SHALL wait indefinitely for imem_ack.
REQ-006 imem_req SHALL be 1 only in FETCH; imem_ack outside FETCH SHALL be ignored.
REQ-007 ISSUE: instr_valid=1; instr_out SHALL stay stable until instr_ready=1, then go to RESOLVE.
REQ-008 RESOLVE: wait for decision_valid=1; in that cycle compute next PC, register it into pc_out, increment instr_count, and go to FETCH.
REQ-009 Next-PC rules, where pc4 = pc_out+4 with wrap modulo 2^32:
  jump=00: pc4
  jump=01: {pc4[31:28], 2'b00, instr_out[25:0]} (unshifted field, per datapath encoding)
  jump=10: j_reg
  jump=11: branch_destiny if branch_result=1, else pc4
REQ-010 jump, j_reg, branch_result and branch_destiny SHALL be sampled only in RESOLVE with decision_valid=1.
REQ-011 instr_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-012 pc_out SHALL change only on the RESOLVE exit cycle.
REQ-013 Minimum cycles per instruction, with imem_ack, instr_ready and decision_valid all asserted on first opportunity: FETCH 1 + ISSUE 1 + RESOLVE 1 = 3.
REQ-014 HALT is entered only per REQ-020; HALT SHALL be exited only by reset.

Reset
REQ-015 While reset_n=0 at a rising edge, the FSM SHALL go to IDLE.
REQ-016 Reset values: pc_out=0, instr_out=0, instr_count=0, misalign_err=0, imem_req=0, instr_valid=0.
REQ-017 A reset asserted mid-fetch or mid-resolve SHALL abort the operation, drop imem_req the following cycle, and discard any pending imem_ack.

Configuration
REQ-018 Macro JR_ALIGN_CHECK_EN SHALL control register-jump alignment checking.
REQ-019 Without the macro: j_reg is used unchecked; misalign_err is tied to 0; HALT is unreachable.
REQ-020 With the macro: in RESOLVE, jump=10 with j_reg[1:0]!=0 SHALL:
  set misalign_err=1 (sticky)
  leave pc_out and instr_count unchanged
  go to HALT, with imem_req=0 and instr_valid=0.

Verification
REQ-021 Reset, then imem_ack on the first FETCH cycle, instr_ready=1, decision_valid=1, jump=00 -> imem_addr=0, then 4, then 8; instr_count increments every 3 cycles.
REQ-022 pc_out=32'h1000_0000, instr=32'h0800_0040, jump=01 -> pc_out=32'h1000_0040.
REQ-023 jump=11: branch_result=1, branch_destiny=32'h200 -> pc_out=32'h200; branch_result=0 from pc_out=32'h200 -> pc_out=32'h204.
REQ-024 Stall checks:
  imem_ack held low 5 cycles -> imem_req high for 6 cycles, addr stable
  instr_ready low 3 cycles -> instr_out stable, pc_out unchanged.
REQ-025 jump=10, j_reg=32'h0000_0102:
  macro on -> misalign_err=1, HALT, no further imem_req until reset_n=0
  macro off -> pc_out=32'h0000_0102.
REQ-026 reset_n=0 during FETCH with imem_ack arriving the same cycle -> instr_out=0, pc_out=0, instr_count=0 after reset.
